// File: rtl/cpu_run_ctrl_if.sv
// Board/core-facing signal bundle of the run-control sequencer.
// slave = sequencer side, master = board + core side.
interface cpu_run_ctrl_if;
  logic        resume;
  logic [1:0]  speed;
  logic        halt;
  logic        cpu_en;
  logic        halted;
  logic        step_mode;
  logic [31:0] en_count;

  modport slave  (input  resume, speed, halt,
                  output cpu_en, halted, step_mode, en_count);
  modport master (output resume, speed, halt,
                  input  cpu_en, halted, step_mode, en_count);
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: debounced resume, synchronized speed select,
// periodic / single-step clock-enable generation and halt handling.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SLOW_SHIFT      = 8
) (
  input  logic           clk,
  input  logic           rst,
  cpu_run_ctrl_if.slave  bus
);
  localparam int PW  = 2 * SLOW_SHIFT;
  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {RUN, HALT} state_t;

  logic           rs_meta_q, rs_sync_q;
  logic [1:0]     sp_meta_q, sp_sync_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           db_q, db_d, db_prev_q, press_q;
  logic [PW-1:0]  per_cnt_q, per_last;
  state_t         state_q;
  logic           cpu_en_q, halted_q, step_mode_q;
  logic [31:0]    en_cnt_q;
  logic           spd_chg, step_sel, periodic_hit;

  // Speed resets to single-step so nothing runs before the real switches land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_meta_q   <= 1'b0;
      rs_sync_q   <= 1'b0;
      sp_meta_q   <= 2'b11;
      sp_sync_q   <= 2'b11;
      step_mode_q <= 1'b1;
    end else begin
      rs_meta_q   <= bus.resume;
      rs_sync_q   <= rs_meta_q;
      sp_meta_q   <= bus.speed;
      sp_sync_q   <= sp_meta_q;
      step_mode_q <= (sp_meta_q == 2'b11);
    end
  end

  always_comb begin
    db_cnt_d = '0;
    db_d     = db_q;
    if (rs_sync_q != db_q) begin
      if (db_cnt_q == DB_LAST) db_d = ~db_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q  <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
      en_cnt_q  <= '0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
      en_cnt_q  <= en_cnt_q + 32'(cpu_en_q);
    end
  end

  always_comb begin
    case (sp_sync_q)
      2'b00:   per_last = '0;
      2'b01:   per_last = {{SLOW_SHIFT{1'b0}}, {SLOW_SHIFT{1'b1}}};
      default: per_last = '1;
    endcase
  end

  // sp_meta differs from sp_sync exactly on the edge that makes a new speed visible.
  assign spd_chg      = (sp_meta_q != sp_sync_q);
  assign step_sel     = (sp_sync_q == 2'b11);
  assign periodic_hit = !step_sel && (per_cnt_q == per_last);

  // Halt is checked before anything else so a coincident press is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cpu_en_q  <= 1'b0;
      halted_q  <= 1'b0;
      per_cnt_q <= '0;
    end else begin
      cpu_en_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (cpu_en_q && bus.halt) begin
            state_q   <= HALT;
            halted_q  <= 1'b1;
            per_cnt_q <= '0;
          end else begin
            if (spd_chg)       per_cnt_q <= '0;
            else if (!step_sel) per_cnt_q <= periodic_hit ? '0 : per_cnt_q + 1'b1;
            cpu_en_q <= periodic_hit || (press_q && step_sel);
          end
        end
        HALT: begin
          per_cnt_q <= '0;
          if (press_q) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            cpu_en_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.cpu_en    = cpu_en_q;
  assign bus.halted    = halted_q;
  assign bus.step_mode = step_mode_q;
  assign bus.en_count  = en_cnt_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl (DEBOUNCE_CYCLES=4, SLOW_SHIFT=2).
// Per-cycle expectations are queued up front and popped as the DUT runs.
module tb_cpu_run_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_run_ctrl_if bus();

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .SLOW_SHIFT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct { bit en; bit hl; } exp_t;
  exp_t exp_q[$];
  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic do_reset(input logic [1:0] spd, input logic res);
    rst = 1'b1; bus.speed = spd; bus.resume = res; bus.halt = 1'b0;
    repeat (2) tick();
    rst = 1'b0; cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.speed = 2'b00; bus.resume = 1'b0; bus.halt = 1'b0;
    repeat (3) tick();
    n_run += 4;
    if (bus.cpu_en !== 1'b0)     begin n_fail++; $display("FAIL reset_cpu_en got=%b exp=0", bus.cpu_en); end
    if (bus.halted !== 1'b0)     begin n_fail++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    if (bus.step_mode !== 1'b1)  begin n_fail++; $display("FAIL reset_step_mode got=%b exp=1", bus.step_mode); end
    if (bus.en_count !== 32'd0)  begin n_fail++; $display("FAIL reset_en_count got=%0d exp=0", bus.en_count); end
  endtask

  task automatic test_full_speed();
    exp_t e;
    do_reset(2'b00, 1'b0);
    for (int c = 1; c <= 13; c++) exp_q.push_back('{en: (c >= 3), hl: 1'b0});
    for (int c = 1; c <= 13; c++) begin
      tick(); e = exp_q.pop_front(); n_run++;
      if (bus.cpu_en !== e.en || bus.halted !== e.hl) begin
        n_fail++; $display("FAIL full_speed cyc=%0d en/halted got=%b%b exp=%b%b", cyc, bus.cpu_en, bus.halted, e.en, e.hl);
      end
      if (c == 1 || c == 2) begin
        n_run++;
        if (bus.step_mode !== (c == 1)) begin n_fail++; $display("FAIL full_step_mode cyc=%0d got=%b exp=%b", cyc, bus.step_mode, c == 1); end
      end
    end
    n_run++;
    if (bus.en_count !== 32'd10) begin n_fail++; $display("FAIL full_en_count got=%0d exp=10", bus.en_count); end
  endtask

  task automatic test_slow_mode();
    exp_t e;
    do_reset(2'b01, 1'b0);
    for (int c = 1; c <= 52; c++) exp_q.push_back('{en: (c inside {6, 10, 14, 33, 49}), hl: 1'b0});
    for (int c = 1; c <= 52; c++) begin
      tick(); e = exp_q.pop_front(); n_run++;
      if (bus.cpu_en !== e.en || bus.halted !== e.hl) begin
        n_fail++; $display("FAIL slow_mode cyc=%0d en/halted got=%b%b exp=%b%b", cyc, bus.cpu_en, bus.halted, e.en, e.hl);
      end
      if (c == 15) bus.speed = 2'b10;
    end
    n_run++;
    if (bus.en_count !== 32'd5) begin n_fail++; $display("FAIL slow_en_count got=%0d exp=5", bus.en_count); end
  endtask

  task automatic test_halt_resume();
    exp_t e;
    do_reset(2'b00, 1'b0);
    for (int c = 1; c <= 120; c++)
      exp_q.push_back('{en: ((c >= 3 && c <= 7) || c >= 116), hl: (c >= 8 && c <= 115)});
    for (int c = 1; c <= 120; c++) begin
      tick(); e = exp_q.pop_front(); n_run++;
      if (bus.cpu_en !== e.en || bus.halted !== e.hl) begin
        n_fail++; $display("FAIL halt_resume cyc=%0d en/halted got=%b%b exp=%b%b", cyc, bus.cpu_en, bus.halted, e.en, e.hl);
      end
      if (c == 7)   bus.halt = 1'b1;
      if (c == 8)   bus.halt = 1'b0;
      if (c == 108) bus.resume = 1'b1;
      if (c == 8 || c == 108) begin
        n_run++;
        if (bus.en_count !== 32'd5) begin n_fail++; $display("FAIL halt_en_count cyc=%0d got=%0d exp=5", cyc, bus.en_count); end
      end
    end
    n_run++;
    if (bus.en_count !== 32'd9) begin n_fail++; $display("FAIL resume_en_count got=%0d exp=9", bus.en_count); end
    bus.resume = 1'b0;
  endtask

  task automatic test_step_bounce();
    exp_t e;
    do_reset(2'b11, 1'b0);
    for (int c = 1; c <= 50; c++) exp_q.push_back('{en: (c inside {12, 38}), hl: 1'b0});
    for (int c = 1; c <= 50; c++) begin
      tick(); e = exp_q.pop_front(); n_run++;
      if (bus.cpu_en !== e.en || bus.halted !== e.hl) begin
        n_fail++; $display("FAIL step_bounce cyc=%0d en/halted got=%b%b exp=%b%b", cyc, bus.cpu_en, bus.halted, e.en, e.hl);
      end
      if (c == 2 || c == 4 || c == 30) bus.resume = 1'b1;
      if (c == 3 || c == 14 || c == 40) bus.resume = 1'b0;
    end
    n_run += 2;
    if (bus.en_count !== 32'd2)  begin n_fail++; $display("FAIL step_en_count got=%0d exp=2", bus.en_count); end
    if (bus.step_mode !== 1'b1)  begin n_fail++; $display("FAIL step_mode got=%b exp=1", bus.step_mode); end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    do_reset(2'b11, 1'b0);
    bus.halt = 1'b1;
    for (int c = 1; c <= 35; c++) exp_q.push_back('{en: (c inside {10, 28}), hl: (c >= 11 && c <= 27)});
    for (int c = 1; c <= 35; c++) begin
      tick(); e = exp_q.pop_front(); n_run++;
      if (bus.cpu_en !== e.en || bus.halted !== e.hl) begin
        n_fail++; $display("FAIL simultaneous cyc=%0d en/halted got=%b%b exp=%b%b", cyc, bus.cpu_en, bus.halted, e.en, e.hl);
      end
      if (c == 11) begin
        n_run++;
        if (bus.en_count !== 32'd1) begin n_fail++; $display("FAIL sim_en_count_halt got=%0d exp=1", bus.en_count); end
      end
      if (c == 2 || c == 20) bus.resume = 1'b1;
      if (c == 14 || c == 30) bus.resume = 1'b0;
      if (c == 12) bus.halt = 1'b0;
    end
    n_run++;
    if (bus.en_count !== 32'd2) begin n_fail++; $display("FAIL sim_en_count_end got=%0d exp=2", bus.en_count); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_reset(2'b00, 1'b0);
    repeat (40) tick();
    n_run++;
    if (bus.en_count !== 32'd37) begin n_fail++; $display("FAIL pre_reset_en_count got=%0d exp=37", bus.en_count); end
    #3 rst = 1'b1; bus.resume = 1'b1; bus.speed = 2'b11;
    #1;
    n_run += 4;
    if (bus.cpu_en !== 1'b0)     begin n_fail++; $display("FAIL async_cpu_en got=%b exp=0", bus.cpu_en); end
    if (bus.halted !== 1'b0)     begin n_fail++; $display("FAIL async_halted got=%b exp=0", bus.halted); end
    if (bus.step_mode !== 1'b1)  begin n_fail++; $display("FAIL async_step_mode got=%b exp=1", bus.step_mode); end
    if (bus.en_count !== 32'd0)  begin n_fail++; $display("FAIL async_en_count got=%0d exp=0", bus.en_count); end
    repeat (3) tick();
    rst = 1'b0; cyc = 0;
    for (int c = 1; c <= 15; c++) exp_q.push_back('{en: (c == 8), hl: 1'b0});
    for (int c = 1; c <= 15; c++) begin
      tick(); e = exp_q.pop_front(); n_run++;
      if (bus.cpu_en !== e.en || bus.halted !== e.hl) begin
        n_fail++; $display("FAIL held_resume cyc=%0d en/halted got=%b%b exp=%b%b", cyc, bus.cpu_en, bus.halted, e.en, e.hl);
      end
    end
    n_run++;
    if (bus.en_count !== 32'd1) begin n_fail++; $display("FAIL held_en_count got=%0d exp=1", bus.en_count); end
  endtask

  initial begin
    bus.resume = 1'b0; bus.speed = 2'b00; bus.halt = 1'b0;
    test_reset();
    test_full_speed();
    test_slow_mode();
    test_halt_resume();
    test_step_bounce();
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
